// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline types and constants for the hazard controller
package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    MEM_WAIT
  } hazard_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_M   = 2'b01;
  localparam logic [1:0] FWD_B   = 2'b10;

endpackage

// File: rtl/riscv_fwd_unit.sv
// rtl/riscv_fwd_unit.sv - E-stage operand forwarding select for one source operand
module riscv_fwd_unit
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  reg_we_m,
  input  logic                  memory2reg_m,
  input  logic [REG_ADDR_W-1:0] dst_addr_m,
  input  logic                  reg_we_b,
  input  logic [REG_ADDR_W-1:0] dst_addr_b,
  output logic [1:0]            sel
);

  // A load in M has no data yet; the load-use bubble lets it be picked up from B.
  always_comb begin
    sel = FWD_REG;
    if (src_addr != '0) begin
      if (reg_we_m && !memory2reg_m && (dst_addr_m == src_addr)) begin
        sel = FWD_M;
      end else if (reg_we_b && (dst_addr_b == src_addr)) begin
        sel = FWD_B;
      end
    end
  end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// rtl/riscv_hazard_ctrl.sv - 5-stage stall/flush/forwarding controller;
// performance counters present only when RISCV_HAZARD_PERF_EN is defined.
module riscv_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned RESET_HOLD  = 2,
  parameter int unsigned BUS_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src1_en_d,
  input  logic                  src2_en_d,
  input  logic [REG_ADDR_W-1:0] src1_addr_d,
  input  logic [REG_ADDR_W-1:0] src2_addr_d,
  input  logic [REG_ADDR_W-1:0] src1_addr_e,
  input  logic [REG_ADDR_W-1:0] src2_addr_e,
  input  logic                  memory2reg_e,
  input  logic                  reg_we_e,
  input  logic [REG_ADDR_W-1:0] dst_addr_e,
  input  logic                  memory2reg_m,
  input  logic                  reg_we_m,
  input  logic [REG_ADDR_W-1:0] dst_addr_m,
  input  logic                  reg_we_b,
  input  logic [REG_ADDR_W-1:0] dst_addr_b,
  input  logic                  ex_branch_m,
  input  logic                  jal_e,
  input  logic                  instr_stall_f,
  input  logic                  bus_stall_m,
  output logic                  stall_f,
  output logic                  stall_fd,
  output logic                  stall_de,
  output logic                  stall_em,
  output logic                  stall_mb,
  output logic                  flush_fd,
  output logic                  flush_de,
  output logic                  flush_em,
  output logic                  flush_mb,
  output logic [1:0]            fwd1_sel_e,
  output logic [1:0]            fwd2_sel_e,
  output logic                  bus_timeout,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int TMR_W  = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

  hazard_state_t    state, state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TMR_W-1:0]  bus_timer;
  logic              hold_done;
  logic              load_use;
  logic [1:0]        fwd1_raw, fwd2_raw;

  // The E-stage write flag is not needed: a load always writes its destination.
  logic unused_reg_we_e;
  assign unused_reg_we_e = reg_we_e;

  assign hold_done = (32'(hold_cnt) + 32'd1) >= RESET_HOLD;

  assign load_use = memory2reg_e && (dst_addr_e != '0) &&
                    ((src1_en_d && (src1_addr_d == dst_addr_e)) ||
                     (src2_en_d && (src2_addr_d == dst_addr_e)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      hold_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == INIT && !hold_done) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_timer   <= '0;
      bus_timeout <= 1'b0;
    end else if (state != INIT && bus_stall_m) begin
      if (bus_timer != TMR_W'(BUS_TIMEOUT)) begin
        bus_timer <= bus_timer + TMR_W'(1);
      end
      if (bus_timer == TMR_W'(BUS_TIMEOUT - 1)) begin
        bus_timeout <= 1'b1;
      end
    end else begin
      bus_timer <= '0;
    end
  end

  // RUN and MEM_WAIT share one decode: leaving MEM_WAIT resolves RUN priority in the same cycle.
  always_comb begin
    state_next = state;
    stall_f    = 1'b0;
    stall_fd   = 1'b0;
    stall_de   = 1'b0;
    stall_em   = 1'b0;
    stall_mb   = 1'b0;
    flush_fd   = 1'b0;
    flush_de   = 1'b0;
    flush_em   = 1'b0;
    flush_mb   = 1'b0;
    if (state == INIT) begin
      stall_f  = 1'b1;
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_em = 1'b1;
      flush_mb = 1'b1;
      if (hold_done) begin
        state_next = RUN;
      end
    end else if (bus_stall_m) begin
      state_next = MEM_WAIT;
      stall_f    = 1'b1;
      stall_fd   = 1'b1;
      stall_de   = 1'b1;
      stall_em   = 1'b1;
      flush_mb   = 1'b1;
    end else begin
      state_next = RUN;
      if (ex_branch_m) begin
        flush_fd = 1'b1;
        flush_de = 1'b1;
        flush_em = 1'b1;
      end else if (jal_e) begin
        flush_fd = 1'b1;
        flush_de = 1'b1;
      end else if (load_use) begin
        stall_f  = 1'b1;
        stall_fd = 1'b1;
        flush_de = 1'b1;
      end else if (instr_stall_f) begin
        stall_f  = 1'b1;
        flush_fd = 1'b1;
      end
    end
    if (rst) begin
      stall_f  = 1'b1;
      stall_fd = 1'b1;
      stall_de = 1'b1;
      stall_em = 1'b1;
      stall_mb = 1'b1;
      flush_fd = 1'b1;
      flush_de = 1'b1;
      flush_em = 1'b1;
      flush_mb = 1'b1;
    end
  end

  riscv_fwd_unit u_fwd1 (
    .src_addr     (src1_addr_e),
    .reg_we_m     (reg_we_m),
    .memory2reg_m (memory2reg_m),
    .dst_addr_m   (dst_addr_m),
    .reg_we_b     (reg_we_b),
    .dst_addr_b   (dst_addr_b),
    .sel          (fwd1_raw)
  );

  riscv_fwd_unit u_fwd2 (
    .src_addr     (src2_addr_e),
    .reg_we_m     (reg_we_m),
    .memory2reg_m (memory2reg_m),
    .dst_addr_m   (dst_addr_m),
    .reg_we_b     (reg_we_b),
    .dst_addr_b   (dst_addr_b),
    .sel          (fwd2_raw)
  );

  assign fwd1_sel_e = rst ? FWD_REG : fwd1_raw;
  assign fwd2_sel_e = rst ? FWD_REG : fwd2_raw;

`ifdef RISCV_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state != INIT && stall_f) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (state == RUN && flush_fd) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb/tb_riscv_hazard_ctrl.sv - directed vector bench for riscv_hazard_ctrl
module tb_riscv_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic src1_en_d, src2_en_d;
  logic [4:0] src1_addr_d, src2_addr_d, src1_addr_e, src2_addr_e;
  logic memory2reg_e, reg_we_e;
  logic [4:0] dst_addr_e;
  logic memory2reg_m, reg_we_m;
  logic [4:0] dst_addr_m;
  logic reg_we_b;
  logic [4:0] dst_addr_b;
  logic ex_branch_m, jal_e, instr_stall_f, bus_stall_m;
  logic stall_f, stall_fd, stall_de, stall_em, stall_mb;
  logic flush_fd, flush_de, flush_em, flush_mb;
  logic [1:0] fwd1_sel_e, fwd2_sel_e;
  logic bus_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;

  always #5 clk = ~clk;

  riscv_hazard_ctrl #(.RESET_HOLD(2), .BUS_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .src1_en_d(src1_en_d), .src2_en_d(src2_en_d),
    .src1_addr_d(src1_addr_d), .src2_addr_d(src2_addr_d),
    .src1_addr_e(src1_addr_e), .src2_addr_e(src2_addr_e),
    .memory2reg_e(memory2reg_e), .reg_we_e(reg_we_e), .dst_addr_e(dst_addr_e),
    .memory2reg_m(memory2reg_m), .reg_we_m(reg_we_m), .dst_addr_m(dst_addr_m),
    .reg_we_b(reg_we_b), .dst_addr_b(dst_addr_b),
    .ex_branch_m(ex_branch_m), .jal_e(jal_e),
    .instr_stall_f(instr_stall_f), .bus_stall_m(bus_stall_m),
    .stall_f(stall_f), .stall_fd(stall_fd), .stall_de(stall_de),
    .stall_em(stall_em), .stall_mb(stall_mb),
    .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em), .flush_mb(flush_mb),
    .fwd1_sel_e(fwd1_sel_e), .fwd2_sel_e(fwd2_sel_e),
    .bus_timeout(bus_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // st = {f,fd,de,em,mb}, fl = {fd,de,em,mb}
  typedef struct {
    string name;
    int m2r_e, dst_e, s1en, s1d, s2en, s2d, jal, br, ist;
    int s1e, s2e, we_m, m2r_m, dst_m, we_b, dst_b;
    int st, fl, f1, f2;
  } vec_t;

  vec_t tbl[16];

  task automatic clear_inputs();
    src1_en_d = 0; src2_en_d = 0; src1_addr_d = 0; src2_addr_d = 0;
    src1_addr_e = 0; src2_addr_e = 0; memory2reg_e = 0; reg_we_e = 0; dst_addr_e = 0;
    memory2reg_m = 0; reg_we_m = 0; dst_addr_m = 0; reg_we_b = 0; dst_addr_b = 0;
    ex_branch_m = 0; jal_e = 0; instr_stall_f = 0; bus_stall_m = 0;
  endtask

  task automatic apply(input vec_t v);
    memory2reg_e = v.m2r_e[0]; reg_we_e = v.m2r_e[0]; dst_addr_e = v.dst_e[4:0];
    src1_en_d = v.s1en[0]; src1_addr_d = v.s1d[4:0];
    src2_en_d = v.s2en[0]; src2_addr_d = v.s2d[4:0];
    jal_e = v.jal[0]; ex_branch_m = v.br[0]; instr_stall_f = v.ist[0];
    src1_addr_e = v.s1e[4:0]; src2_addr_e = v.s2e[4:0];
    reg_we_m = v.we_m[0]; memory2reg_m = v.m2r_m[0]; dst_addr_m = v.dst_m[4:0];
    reg_we_b = v.we_b[0]; dst_addr_b = v.dst_b[4:0];
    bus_stall_m = 0;
  endtask

  task automatic check_out(input string nm, input int st, input int fl, input int f1, input int f2);
    int a_st, a_fl, a_f1, a_f2;
    a_st = int'({stall_f, stall_fd, stall_de, stall_em, stall_mb});
    a_fl = int'({flush_fd, flush_de, flush_em, flush_mb});
    a_f1 = int'(fwd1_sel_e);
    a_f2 = int'(fwd2_sel_e);
    checks++;
    if (a_st !== st || a_fl !== fl || a_f1 !== f1 || a_f2 !== f2) begin
      failures++;
      $display("FAIL %s: got stall=%05b flush=%04b fwd1=%02b fwd2=%02b, want stall=%05b flush=%04b fwd1=%02b fwd2=%02b",
               nm, a_st[4:0], a_fl[3:0], a_f1[1:0], a_f2[1:0], st[4:0], fl[3:0], f1[1:0], f2[1:0]);
    end
  endtask

  task automatic check_val(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Advance one clock, updating the bench's model of the performance counters.
  task automatic tick(input int in_run, input int in_mw, input int exp_sf, input int exp_ffd);
    if ((in_run != 0 || in_mw != 0) && exp_sf != 0) exp_stall_cnt++;
    if (in_run != 0 && exp_ffd != 0) exp_flush_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(input string nm);
`ifdef RISCV_HAZARD_PERF_EN
    check_val({nm, "_stall_cnt"}, int'(stall_cnt), exp_stall_cnt);
    check_val({nm, "_flush_cnt"}, int'(flush_cnt), exp_flush_cnt);
`else
    check_val({nm, "_stall_cnt"}, int'(stall_cnt), 0);
    check_val({nm, "_flush_cnt"}, int'(flush_cnt), 0);
`endif
  endtask

  initial begin
    //            name          m2r dst s1en s1d s2en s2d jal br ist s1e s2e wem m2rm dm web db   st        fl       f1 f2
    tbl[0]  = '{"idle",          0,  0,  0,   0,  0,   0,  0,  0, 0,  0,  0,  0,  0,   0, 0,  0, 'b00000, 'b0000, 0, 0};
    tbl[1]  = '{"lu_src1",       1,  5,  1,   5,  0,   0,  0,  0, 0,  0,  0,  0,  0,   0, 0,  0, 'b11000, 'b0100, 0, 0};
    tbl[2]  = '{"lu_drained",    0,  0,  1,   5,  0,   0,  0,  0, 0,  0,  0,  0,  0,   0, 0,  0, 'b00000, 'b0000, 0, 0};
    tbl[3]  = '{"lu_dst0",       1,  0,  1,   0,  0,   0,  0,  0, 0,  0,  0,  0,  0,   0, 0,  0, 'b00000, 'b0000, 0, 0};
    tbl[4]  = '{"lu_src2_off",   1,  9,  0,   0,  0,   9,  0,  0, 0,  0,  0,  0,  0,   0, 0,  0, 'b00000, 'b0000, 0, 0};
    tbl[5]  = '{"lu_src2",       1,  9,  0,   0,  1,   9,  0,  0, 0,  0,  0,  0,  0,   0, 0,  0, 'b11000, 'b0100, 0, 0};
    tbl[6]  = '{"lu_and_istall", 1, 12,  1,  12,  0,   0,  0,  0, 1,  0,  0,  0,  0,   0, 0,  0, 'b11000, 'b0100, 0, 0};
    tbl[7]  = '{"istall",        0,  0,  0,   0,  0,   0,  0,  0, 1,  0,  0,  0,  0,   0, 0,  0, 'b10000, 'b1000, 0, 0};
    tbl[8]  = '{"jal",           0,  0,  0,   0,  0,   0,  1,  0, 0,  0,  0,  0,  0,   0, 0,  0, 'b00000, 'b1100, 0, 0};
    tbl[9]  = '{"branch",        0,  0,  0,   0,  0,   0,  0,  1, 0,  0,  0,  0,  0,   0, 0,  0, 'b00000, 'b1110, 0, 0};
    tbl[10] = '{"jal_over_lu",   1,  5,  1,   5,  0,   0,  1,  0, 0,  0,  0,  0,  0,   0, 0,  0, 'b00000, 'b1100, 0, 0};
    tbl[11] = '{"fwd_m_over_b",  0,  0,  0,   0,  0,   0,  0,  0, 0,  7,  0,  1,  0,   7, 1,  7, 'b00000, 'b0000, 1, 0};
    tbl[12] = '{"fwd_load_m_b",  0,  0,  0,   0,  0,   0,  0,  0, 0,  7,  0,  1,  1,   7, 1,  7, 'b00000, 'b0000, 2, 0};
    tbl[13] = '{"fwd_x0",        0,  0,  0,   0,  0,   0,  0,  0, 0,  0,  0,  1,  0,   0, 1,  0, 'b00000, 'b0000, 0, 0};
    tbl[14] = '{"fwd2_b",        0,  0,  0,   0,  0,   0,  0,  0, 0,  4,  3,  1,  0,   6, 1,  3, 'b00000, 'b0000, 0, 2};
    tbl[15] = '{"fwd_m_nowe",    0,  0,  0,   0,  0,   0,  0,  0, 0,  6,  6,  0,  0,   6, 0,  6, 'b00000, 'b0000, 0, 0};

    clear_inputs();
    rst = 1;
    src1_addr_e = 7; reg_we_m = 1; dst_addr_m = 7;
    repeat (2) @(posedge clk);
    #1;
    check_out("in_reset", 'b11111, 'b1111, 0, 0);
    check_val("reset_timeout", int'(bus_timeout), 0);
    check_perf("reset");

    clear_inputs();
    rst = 0;
    #1;
    check_out("init_cycle0", 'b10000, 'b1111, 0, 0);
    tick(0, 0, 1, 1);
    check_out("init_cycle1", 'b10000, 'b1111, 0, 0);
    tick(0, 0, 1, 1);
    check_out("run_idle", 'b00000, 'b0000, 0, 0);
    tick(1, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i]);
      #1;
      check_out(tbl[i].name, tbl[i].st, tbl[i].fl, tbl[i].f1, tbl[i].f2);
      tick(1, 0, (tbl[i].st >> 4) & 1, (tbl[i].fl >> 3) & 1);
    end

    // Branch and jal together: branch wins, one flush_fd cycle counted.
    clear_inputs();
    ex_branch_m = 1; jal_e = 1;
    #1;
    check_out("branch_with_jal", 'b00000, 'b1110, 0, 0);
    tick(1, 0, 0, 1);
    clear_inputs();
    #1;
    check_perf("after_branch_jal");

    // Bus wait hiding a pending branch, then redirect in the release cycle.
    for (int k = 0; k < 3; k++) begin
      bus_stall_m = 1; ex_branch_m = 1;
      #1;
      check_out($sformatf("bus_wait_%0d", k), 'b11110, 'b0001, 0, 0);
      tick((k == 0) ? 1 : 0, (k == 0) ? 0 : 1, 1, 0);
    end
    bus_stall_m = 0;
    #1;
    check_out("bus_release_branch", 'b00000, 'b1110, 0, 0);
    check_val("no_timeout_3", int'(bus_timeout), 0);
    tick(0, 1, 0, 1);
    clear_inputs();
    #1;
    check_out("after_release_idle", 'b00000, 'b0000, 0, 0);
    tick(1, 0, 0, 0);
    check_perf("after_bus_wait");

    // Timeout: six stall cycles, flag registered at the end of the fourth.
    for (int k = 1; k <= 6; k++) begin
      bus_stall_m = 1;
      #1;
      check_out($sformatf("to_stall_%0d", k), 'b11110, 'b0001, 0, 0);
      check_val($sformatf("to_flag_%0d", k), int'(bus_timeout), (k >= 5) ? 1 : 0);
      tick((k == 1) ? 1 : 0, (k == 1) ? 0 : 1, 1, 0);
    end
    bus_stall_m = 0;
    #1;
    check_val("to_sticky_release", int'(bus_timeout), 1);
    tick(0, 1, 0, 0);
    check_out("to_run_idle", 'b00000, 'b0000, 0, 0);
    check_val("to_sticky_run", int'(bus_timeout), 1);
    tick(1, 0, 0, 0);
    check_perf("after_timeout");

    // Reset in the middle of a bus wait.
    bus_stall_m = 1;
    #1;
    tick(1, 0, 1, 0);
    #2;
    rst = 1;
    #1;
    check_out("mid_wait_reset", 'b11111, 'b1111, 0, 0);
    check_val("reset_clears_timeout", int'(bus_timeout), 0);
    exp_stall_cnt = 0;
    exp_flush_cnt = 0;
    check_perf("mid_wait_reset");
    bus_stall_m = 0;
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    check_out("reinit_cycle0", 'b10000, 'b1111, 0, 0);
    tick(0, 0, 1, 1);
    check_out("reinit_cycle1", 'b10000, 'b1111, 0, 0);
    tick(0, 0, 1, 1);
    check_out("rerun_idle", 'b00000, 'b0000, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
